// File: rtl/agc_pkg.sv
// Shared types and default widths for the AGC I/Q test source.
package agc_pkg;
  localparam int W_IN     = 16;
  localparam int CNTWIDTH = 16;
  localparam int DIVWIDTH = 8;
  localparam int NCWIDTH  = 8;

  localparam logic signed [W_IN-1:0] SMAX = {1'b0, {(W_IN-1){1'b1}}};
  localparam logic signed [W_IN-1:0] SMIN = {1'b1, {(W_IN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SEG_A, SEG_B, DONE} state_e;
endpackage

// File: rtl/quad_phase_gen.sv
// Registered quadrature sample: (X,0),(0,X),(-X,0),(0,-X) by phase, negation saturating.
module quad_phase_gen #(
  parameter int W = agc_pkg::W_IN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [1:0]          phase,
  input  logic signed [W-1:0] amp,
  output logic signed [W-1:0] data_i,
  output logic signed [W-1:0] data_q
);
  localparam logic signed [W-1:0] NMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] NMIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] neg;
  assign neg = (amp == NMIN) ? NMAX : -amp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_i <= '0;
      data_q <= '0;
    end else if (clr) begin
      data_i <= '0;
      data_q <= '0;
    end else if (load) begin
      case (phase)
        2'd0: begin data_i <= amp; data_q <= '0;  end
        2'd1: begin data_i <= '0;  data_q <= amp; end
        2'd2: begin data_i <= neg; data_q <= '0;  end
        default: begin data_i <= '0; data_q <= neg; end
      endcase
    end
  end
endmodule

// File: rtl/agc_iq_source.sv
// Paced I/Q step-amplitude source: alternates A/B segments of constant-envelope quadrature samples.
module agc_iq_source #(
  parameter int W_IN     = agc_pkg::W_IN,
  parameter int CNTWIDTH = agc_pkg::CNTWIDTH,
  parameter int DIVWIDTH = agc_pkg::DIVWIDTH,
  parameter int NCWIDTH  = agc_pkg::NCWIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic signed [W_IN-1:0] amp_a,
  input  logic signed [W_IN-1:0] amp_b,
  input  logic [CNTWIDTH-1:0]    seg_len,
  input  logic [DIVWIDTH-1:0]    rate_div,
  input  logic [NCWIDTH-1:0]     n_cycles,
  output logic signed [W_IN-1:0] m_chans_dataI,
  output logic signed [W_IN-1:0] m_chans_dataQ,
  output logic                   m_chans_valid,
  output logic                   busy,
  output logic                   done
);
  import agc_pkg::*;

  state_e                state;
  logic signed [W_IN-1:0] amp_a_r, amp_b_r, amp_sel;
  logic [CNTWIDTH-1:0]   seg_len_r, cnt;
  logic [DIVWIDTH-1:0]   rate_div_r, div_cnt;
  logic [NCWIDTH-1:0]    n_cycles_r, pairs;
  logic [1:0]            phase, phase_sel;
  logic start_ok, active, pace, seg_end, last_pair, to_done, emit, clr, use_b;

  // Segment boundaries are resolved on the edge after a segment's last sample, so the
  // next sample (if paced on that edge) already belongs to the following segment.
  always_comb begin
    start_ok  = (state == IDLE) && start && !stop;
    active    = (state == SEG_A) || (state == SEG_B);
    pace      = (div_cnt == rate_div_r);
    seg_end   = (cnt == seg_len_r);
    last_pair = (n_cycles_r != '0) && (pairs + NCWIDTH'(1) == n_cycles_r);
    to_done   = active && seg_end && (state == SEG_B) && last_pair;
    emit      = start_ok || (active && !stop && pace && !to_done);
    use_b     = (state == SEG_B) ^ seg_end;
    amp_sel   = start_ok ? amp_a : (use_b ? amp_b_r : amp_a_r);
    phase_sel = start_ok ? 2'd0 : phase;
    clr       = (state == DONE) || (active && stop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      amp_a_r <= '0; amp_b_r <= '0;
      seg_len_r <= '0; rate_div_r <= '0; n_cycles_r <= '0;
      cnt <= '0; div_cnt <= '0; pairs <= '0; phase <= '0;
      m_chans_valid <= 1'b0; busy <= 1'b0; done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m_chans_valid <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start_ok) begin
            amp_a_r    <= amp_a;
            amp_b_r    <= amp_b;
            seg_len_r  <= (seg_len == '0) ? CNTWIDTH'(1) : seg_len;
            rate_div_r <= rate_div;
            n_cycles_r <= n_cycles;
            cnt        <= CNTWIDTH'(1);
            div_cnt    <= '0;
            pairs      <= '0;
            phase      <= 2'd1;
            state      <= SEG_A;
            busy       <= 1'b1;
            m_chans_valid <= 1'b1;
          end
        end
        SEG_A, SEG_B: begin
          if (stop) begin
            state <= IDLE;
            busy <= 1'b0;
            m_chans_valid <= 1'b0;
          end else begin
            m_chans_valid <= emit;
            div_cnt <= pace ? '0 : div_cnt + DIVWIDTH'(1);
            if (emit) phase <= phase + 2'd1;
            if (seg_end) begin
              cnt <= emit ? CNTWIDTH'(1) : '0;
              if (state == SEG_A) state <= SEG_B;
              else begin
                pairs <= pairs + NCWIDTH'(1);
                state <= last_pair ? DONE : SEG_A;
              end
            end else begin
              cnt <= cnt + CNTWIDTH'(emit);
            end
            if (to_done) begin
              busy <= 1'b0;
              done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
          m_chans_valid <= 1'b0;
        end
      endcase
    end
  end

  quad_phase_gen #(.W(W_IN)) u_qgen (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(emit),
    .phase(phase_sel), .amp(amp_sel),
    .data_i(m_chans_dataI), .data_q(m_chans_dataQ)
  );
endmodule

// File: tb/tb_agc_iq_source.sv
// Directed bench for agc_iq_source: sequence, pacing, saturation, stop, reset and edge cases.
module tb_agc_iq_source;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic signed [15:0] amp_a = '0, amp_b = '0;
  logic [15:0] seg_len = '0;
  logic [7:0]  rate_div = '0, n_cycles = '0;
  logic signed [15:0] di, dq;
  logic valid, busy, done;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  agc_iq_source dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .amp_a(amp_a), .amp_b(amp_b), .seg_len(seg_len), .rate_div(rate_div),
    .n_cycles(n_cycles), .m_chans_dataI(di), .m_chans_dataQ(dq),
    .m_chans_valid(valid), .busy(busy), .done(done)
  );

  // Returns at the negedge of the cycle following the start edge.
  task automatic do_start(input logic [15:0] a, input logic [15:0] b, input logic [15:0] len,
                          input logic [7:0] div, input logic [7:0] n);
    @(negedge clk);
    amp_a = a; amp_b = b; seg_len = len; rate_div = div; n_cycles = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({valid, busy, done, di, dq} !== 35'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b b=%b d=%b i=%h q=%h want all 0", valid, busy, done, di, dq);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got busy=%b valid=%b want 0 0", busy, valid);
    end
  endtask

  task automatic test_basic;
    logic [15:0] ei [8] = '{16'h2000, 16'h0000, 16'hE000, 16'h0000, 16'h0800, 16'h0000, 16'hF800, 16'h0000};
    logic [15:0] eq [8] = '{16'h0000, 16'h2000, 16'h0000, 16'hE000, 16'h0000, 16'h0800, 16'h0000, 16'hF800};
    do_start(16'h2000, 16'h0800, 16'd4, 8'd0, 8'd1);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || di !== ei[i] || dq !== eq[i]) begin
        n_fail++; $display("FAIL basic_sample[%0d]: got v=%b b=%b (%h,%h) want v=1 b=1 (%h,%h)", i, valid, busy, di, dq, ei[i], eq[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got done=%b busy=%b valid=%b want 1 0 0", done, busy, valid);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || di !== 16'h0 || dq !== 16'h0) begin
      n_fail++; $display("FAIL basic_idle: got done=%b i=%h q=%h want 0 0 0", done, di, dq);
    end
  endtask

  task automatic test_pacing;
    logic [15:0] ei [4] = '{16'h1000, 16'h0000, 16'hFC00, 16'h0000};
    logic [15:0] eq [4] = '{16'h0000, 16'h1000, 16'h0000, 16'hFC00};
    do_start(16'h1000, 16'h0400, 16'd2, 8'd3, 8'd1);
    for (int t = 0; t < 13; t++) begin
      n_checks++;
      if (valid !== (t % 4 == 0) || busy !== 1'b1 || di !== ei[t/4] || dq !== eq[t/4]) begin
        n_fail++; $display("FAIL pacing[t=%0d]: got v=%b b=%b (%h,%h) want v=%0d b=1 (%h,%h)", t, valid, busy, di, dq, (t % 4 == 0), ei[t/4], eq[t/4]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL pacing_done: got done=%b busy=%b want 1 0", done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_saturation;
    logic [15:0] ei [8] = '{16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] eq [8] = '{16'h0000, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF};
    do_start(16'h8000, 16'h0001, 16'd4, 8'd0, 8'd1);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (valid !== 1'b1 || di !== ei[i] || dq !== eq[i]) begin
        n_fail++; $display("FAIL sat_sample[%0d]: got v=%b (%h,%h) want v=1 (%h,%h)", i, valid, di, dq, ei[i], eq[i]);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_stop;
    do_start(16'h0100, 16'h0200, 16'd4, 8'd0, 8'd1);
    repeat (2) @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || di !== 16'hFF00) begin
      n_fail++; $display("FAIL stop_third: got v=%b i=%h want 1 ff00", valid, di);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if ({valid, busy, done, di, dq} !== 35'd0) begin
      n_fail++; $display("FAIL stop_drop: got v=%b b=%b d=%b i=%h q=%h want all 0", valid, busy, done, di, dq);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (valid !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL stop_quiet[%0d]: got v=%b d=%b want 0 0", i, valid, done);
      end
      @(negedge clk);
    end
    do_start(16'h0300, 16'h0400, 16'd1, 8'd0, 8'd1);
    n_checks++;
    if (valid !== 1'b1 || busy !== 1'b1 || di !== 16'h0300 || dq !== 16'h0) begin
      n_fail++; $display("FAIL stop_restart0: got v=%b b=%b (%h,%h) want 1 1 (0300,0000)", valid, busy, di, dq);
    end
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b1 || di !== 16'h0 || dq !== 16'h0400) begin
      n_fail++; $display("FAIL stop_restart1: got v=%b (%h,%h) want 1 (0000,0400)", valid, di, dq);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL stop_restart_done: got done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    do_start(16'h1234, 16'h0456, 16'd3, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({valid, busy, done, di, dq} !== 35'd0) begin
      n_fail++; $display("FAIL async_reset: got v=%b b=%b d=%b i=%h q=%h want all 0", valid, busy, done, di, dq);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || di !== 16'h0) begin
      n_fail++; $display("FAIL async_idle: got v=%b b=%b i=%h want 0 0 0", valid, busy, di);
    end
  endtask

  task automatic test_start_busy;
    logic [15:0] ei [4] = '{16'h0100, 16'h0000, 16'hFE00, 16'h0000};
    logic [15:0] eq [4] = '{16'h0000, 16'h0100, 16'h0000, 16'hFE00};
    do_start(16'h0100, 16'h0200, 16'd2, 8'd0, 8'd1);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (valid !== 1'b1 || di !== ei[i] || dq !== eq[i]) begin
        n_fail++; $display("FAIL busy_start[%0d]: got v=%b (%h,%h) want 1 (%h,%h)", i, valid, di, dq, ei[i], eq[i]);
      end
      if (i == 0) begin
        start = 1'b1; amp_a = 16'h7000; amp_b = 16'h6000; seg_len = 16'd9;
      end else start = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL busy_start_done: got done=%b want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_seglen0;
    logic [15:0] ei [4] = '{16'h0010, 16'h0000, 16'hFFF0, 16'h0000};
    logic [15:0] eq [4] = '{16'h0000, 16'h0020, 16'h0000, 16'hFFE0};
    do_start(16'h0010, 16'h0020, 16'd0, 8'd0, 8'd2);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (valid !== 1'b1 || di !== ei[i] || dq !== eq[i]) begin
        n_fail++; $display("FAIL seglen0[%0d]: got v=%b (%h,%h) want 1 (%h,%h)", i, valid, di, dq, ei[i], eq[i]);
      end
      @(negedge clk);
    end
    n_checks++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_fail++; $display("FAIL seglen0_done: got done=%b valid=%b want 1 0", done, valid);
    end
    @(negedge clk);
  endtask

  task automatic test_infinite;
    int strobes = 0, bad = 0;
    do_start(16'h0001, 16'h0002, 16'd3, 8'd0, 8'd0);
    for (int t = 0; t < 1100; t++) begin
      if (valid === 1'b1) strobes++;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (strobes != 1100 || bad != 0) begin
      n_fail++; $display("FAIL infinite_run: got strobes=%0d bad=%0d want 1100 0", strobes, bad);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL infinite_stop: got v=%b b=%b d=%b want 0 0 0", valid, busy, done);
    end
  endtask

  task automatic test_start_stop_idle;
    @(negedge clk);
    amp_a = 16'h0100; seg_len = 16'd2; n_cycles = 8'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL start_stop_idle[%0d]: got v=%b b=%b want 0 0", i, valid, busy);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_pacing();
    test_saturation();
    test_stop();
    test_async_reset();
    test_start_busy();
    test_seglen0();
    test_infinite();
    test_start_stop_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/agc_iq_source.md
# agc_iq_source

Paced I/Q sample transmitter that drives the AGC's `s_chans_dataI/Q/valid` input stream. It produces a constant-envelope quadrature test signal whose amplitude alternates between two programmed levels, A and B, in fixed-length segments. Each level step exercises the AGC loop: gain multiply, magnitude, EMA, error and feedback. The block sits upstream of the AGC in the lab and simulation datapath and is the producer end of the same valid-qualified sample interface.

## Interface
- `W_IN`, 16: sample width, signed two's complement; matches AGC `W_IN`
- `CNTWIDTH`, 16: width of segment-length counter
- `DIVWIDTH`, 8: width of rate divider
- `NCWIDTH`, 8: width of A/B cycle counter

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  pulse; accepted only in IDLE
- `stop`  in  1  abort request; honoured in any active state
- `amp_a`  in  W_IN  signed amplitude, segment A; latched on accepted start
- `amp_b`  in  W_IN  signed amplitude, segment B; latched on accepted start
- `seg_len`  in  CNTWIDTH  samples per segment; 0 treated as 1; latched on start
- `rate_div`  in  DIVWIDTH  one valid every `rate_div+1` clocks; latched on start
- `n_cycles`  in  NCWIDTH  number of A+B pairs; 0 = run until `stop`; latched on start
- `m_chans_dataI`  out  W_IN  I sample, registered
- `m_chans_dataQ`  out  W_IN  Q sample, registered
- `m_chans_valid`  out  1  one-clock strobe per sample
- `busy`  out  1  high in SEG_A and SEG_B
- `done`  out  1  one-clock pulse on normal completion

## Operation
- FSM states:
  - IDLE: `start` & !`stop` -> SEG_A, parameters latched.
  - SEG_A: after `seg_len` samples -> SEG_B.
  - SEG_B: after `seg_len` samples, pair count +1. If pairs == `n_cycles` (and `n_cycles` != 0) -> DONE, else -> SEG_A.
  - DONE: -> IDLE unconditionally.
- `stop` in SEG_A/SEG_B/DONE -> IDLE next clock, with no `done` pulse.
- Quadrature sequence: a 2-bit phase advances once per emitted sample and is cleared on start. It continues across segment boundaries without resetting.
  - Phase 0: (X, 0). Phase 1: (0, X). Phase 2: (−X, 0). Phase 3: (0, −X). X = current segment amplitude.
- Negation saturates: −(0x8000) = 0x7FFF. All other values use exact two's complement.
- Data outputs hold the last sample between strobes. They are cleared to 0 on entry to IDLE, whether by stop, by completion or by reset.
- `start` while not IDLE is ignored. `start` and `stop` together in IDLE: `stop` wins and nothing starts.
- Reset: state IDLE; all counters 0; every output (`m_chans_*`, `busy`, `done`) reads 0 while `rst_n` is low. This holds even if reset is asserted mid-run.

## Timing
- `start` sampled high at edge k -> `busy` and the first `m_chans_valid` are high in the cycle after edge k.
- Subsequent strobes come every `rate_div+1` clocks. With `rate_div`=0, valid is continuous.
- Segment switch is seamless: the first B sample follows the last A sample at the normal pacing interval.
- Last sample strobe in cycle c -> the FSM enters DONE at the next edge, so `done`=1 and `busy`=0 in cycle c+1 and everything is idle in cycle c+2.
- `stop` sampled at edge k -> `m_chans_valid`=0 and `busy`=0 from the cycle after edge k. No further strobes.
- The pacing divider restarts at 0 on every accepted start.

## Structure
- Shared package `agc_pkg`:
  - FSM state enum (IDLE, SEG_A, SEG_B, DONE)
  - default widths `W_IN`, `CNTWIDTH`, `DIVWIDTH`, `NCWIDTH`
  - saturation constants `SMAX`, `SMIN`
- One sub-module, `quad_phase_gen`: 2-bit phase plus amplitude in -> registered I/Q out, containing the saturating negation.
- The top level holds the FSM, pacing divider, sample counter and pair counter.

## Test plan
- Basic two-segment run: `amp_a`=0x2000, `amp_b`=0x0800, `seg_len`=4, `rate_div`=0, `n_cycles`=1, start.
  - Expect 8 consecutive strobes: (2000,0), (0,2000), (E000,0), (0,E000), then (0800,0), (0,0800), (F800,0), (0,F800).
  - `done` one cycle after the 8th strobe.
- Pacing: `rate_div`=3, `seg_len`=2.
  - Strobes exactly 4 clocks apart.
  - Data stable between strobes.
  - `busy` high throughout.
- Saturation: `amp_a`=0x8000.
  - Phase 2 I = 0x7FFF and phase 3 Q = 0x7FFF.
  - Phases 0/1 = 0x8000.
- Stop mid-segment: stop at the 3rd strobe.
  - Valid and busy drop the next cycle.
  - No `done`; data = 0.
  - A new start is accepted afterwards.
- Async reset mid-run: deassert `rst_n` between clock edges.
  - All outputs 0 immediately.
  - After release, IDLE until `start`.
- Edge cases:
  - `start` while busy is ignored.
  - `seg_len`=0 alternates A/B every sample.
  - `n_cycles`=0 runs for more than 1000 strobes until `stop`.
  - `start` and `stop` together in IDLE gives no run.
